multicycle_ctrl_fsm: RTL

- Multi-cycle sequencer for the RV32I datapath: PC, instruction memory, register file, ALU, data memory and write-back mux.
- Replaces the single-cycle opcode decoder.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with a shared memory port, counts retired instructions and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctrl_fsm.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port, with retired-instruction counting and sticky trap flags.
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_isel,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             pc_src,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             bus_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Counter only needs to reach MEM_TIMEOUT-1: the final waiting cycle traps.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            stQ, stD;
  logic [6:0]        opQ;
  logic [WAIT_W-1:0] waitCnt;
  logic              retire, setIll, setBerr, legal;

  assign state = stQ;
  assign legal = opQ inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};

  always_comb begin
    stD      = stQ;
    mem_req  = 1'b0;
    mem_isel = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    pc_src   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    wb_sel   = 2'b00;
    retire   = 1'b0;
    setIll   = 1'b0;
    setBerr  = 1'b0;
    case (stQ)
      IDLE: if (run) stD = FETCH;
      FETCH: begin
        mem_req  = 1'b1;
        mem_isel = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          stD     = DECODE;
        end else if (waitCnt == WAIT_LAST) begin
          setBerr = 1'b1;
          stD     = TRAP;
        end
      end
      DECODE: begin
        if (legal) begin
          stD = EXEC;
        end else begin
          setIll = 1'b1;
          stD    = TRAP;
        end
      end
      EXEC: begin
        case (opQ)
          OP_R: begin
            ALUOp = 2'b10;
            stD   = WB;
          end
          OP_I: begin
            ALUSrc = 1'b1;
            ALUOp  = 2'b10;
            stD    = WB;
          end
          OP_LD, OP_ST: begin
            ALUSrc = 1'b1;
            stD    = MEM;
          end
          OP_BR: begin
            ALUOp   = 2'b01;
            PCWrite = 1'b1;
            pc_src  = alu_zero;
            retire  = 1'b1;
          end
          OP_JAL:  stD = WB;
          default: stD = TRAP;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        ALUSrc   = 1'b1;
        MemRead  = (opQ == OP_LD);
        MemWrite = (opQ == OP_ST);
        if (mem_ready) begin
          if (opQ == OP_ST) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
          end else begin
            stD = WB;
          end
        end else if (waitCnt == WAIT_LAST) begin
          setBerr = 1'b1;
          stD     = TRAP;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        retire   = 1'b1;
        if (opQ == OP_LD) begin
          wb_sel = 2'b01;
        end else if (opQ == OP_JAL) begin
          wb_sel = 2'b10;
          pc_src = 1'b1;
        end
      end
      TRAP:    stD = TRAP;
      default: stD = IDLE;
    endcase
    if (retire) stD = run ? FETCH : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stQ     <= IDLE;
      opQ     <= '0;
      waitCnt <= '0;
      instret <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      stQ <= stD;
      if (stQ == FETCH && mem_ready) opQ <= opcode;
      if (retire) instret <= instret + CNT_W'(1);
      if (setIll) illegal <= 1'b1;
      if (setBerr) bus_err <= 1'b1;
      if (stD != stQ) begin
        waitCnt <= '0;
      end else if ((stQ == FETCH || stQ == MEM) && !mem_ready) begin
        waitCnt <= waitCnt + WAIT_W'(1);
      end
    end
  end

endmodule
